// File: rtl/clock_set_ctrl.sv
// MM:SS time-set controller: key conditioning, four-digit edit FSM, hold/load and blink masks.
// Optional idle timeout is compiled in with `define SET_TIMEOUT_EN.
module clock_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLINK_CYCLES    = 12500000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic       CLOCK_50_B5B,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic       key_dec_n,
  input  logic [4:0] cur_s1,
  input  logic [4:0] cur_s10,
  input  logic [4:0] cur_m1,
  input  logic [4:0] cur_m10,
  output logic       hold,
  output logic       load,
  output logic [4:0] ld_s1,
  output logic [4:0] ld_s10,
  output logic [4:0] ld_m1,
  output logic [4:0] ld_m10,
  output logic [3:0] blink_mask,
  output logic       editing
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BL_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RUN, ST_SET_M10, ST_SET_M1, ST_SET_S10, ST_SET_S1, ST_COMMIT
  } state_t;

  state_t state_q, state_d;

  // Key index: 0 = mode, 1 = inc, 2 = dec; internal level 1 = pressed.
  logic [2:0]      key_raw;
  logic [2:0]      sync1_q, sync2_q, deb_q, deb_prev_q, evt_q;
  logic [DB_W-1:0] db_cnt_q [3];

  assign key_raw = {~key_dec_n, ~key_inc_n, ~key_mode_n};

  always_ff @(posedge CLOCK_50_B5B or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      evt_q      <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= key_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      evt_q      <= deb_q & ~deb_prev_q;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (db_cnt_q[i] == DB_MAX) begin
            deb_q[i]    <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic mode_evt, inc_evt, dec_evt, any_evt, is_set, edit_en;

  assign mode_evt = evt_q[0];
  assign inc_evt  = evt_q[1];
  assign dec_evt  = evt_q[2];
  assign any_evt  = |evt_q;
  assign is_set   = (state_q == ST_SET_M10) || (state_q == ST_SET_M1) ||
                    (state_q == ST_SET_S10) || (state_q == ST_SET_S1);
  // Mode wins over inc/dec; inc together with dec cancels out.
  assign edit_en  = is_set && !mode_evt && (inc_evt ^ dec_evt);

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [3:0] step(input logic [3:0] v, input logic [3:0] mx,
                                      input logic up);
    if (up) return (v >= mx) ? 4'd0 : v + 4'd1;
    else    return (v == 4'd0) ? mx : v - 4'd1;
  endfunction

  logic timeout_hit;

`ifdef SET_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] idle_q;

  always_ff @(posedge CLOCK_50_B5B or negedge rst_n) begin
    if (!rst_n)                 idle_q <= '0;
    else if (!is_set || any_evt) idle_q <= '0;
    else if (idle_q != TO_MAX)   idle_q <= idle_q + 1'b1;
  end

  assign timeout_hit = is_set && (idle_q == TO_MAX);
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLOCK_50_B5B or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:     if (mode_evt) state_d = ST_SET_M10;
      ST_SET_M10: if (mode_evt) state_d = ST_SET_M1;
                  else if (timeout_hit && !any_evt) state_d = ST_RUN;
      ST_SET_M1:  if (mode_evt) state_d = ST_SET_S10;
                  else if (timeout_hit && !any_evt) state_d = ST_RUN;
      ST_SET_S10: if (mode_evt) state_d = ST_SET_S1;
                  else if (timeout_hit && !any_evt) state_d = ST_RUN;
      ST_SET_S1:  if (mode_evt) state_d = ST_COMMIT;
                  else if (timeout_hit && !any_evt) state_d = ST_RUN;
      ST_COMMIT:  state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  logic [3:0] e_m10_q, e_m1_q, e_s10_q, e_s1_q;

  always_ff @(posedge CLOCK_50_B5B or negedge rst_n) begin
    if (!rst_n) begin
      e_m10_q <= '0;
      e_m1_q  <= '0;
      e_s10_q <= '0;
      e_s1_q  <= '0;
    end else if (state_q == ST_RUN && mode_evt) begin
      e_m10_q <= clamp(cur_m10[3:0], 4'd5);
      e_m1_q  <= clamp(cur_m1[3:0],  4'd9);
      e_s10_q <= clamp(cur_s10[3:0], 4'd5);
      e_s1_q  <= clamp(cur_s1[3:0],  4'd9);
    end else if (edit_en) begin
      unique case (state_q)
        ST_SET_M10: e_m10_q <= step(e_m10_q, 4'd5, inc_evt);
        ST_SET_M1:  e_m1_q  <= step(e_m1_q,  4'd9, inc_evt);
        ST_SET_S10: e_s10_q <= step(e_s10_q, 4'd5, inc_evt);
        ST_SET_S1:  e_s1_q  <= step(e_s1_q,  4'd9, inc_evt);
        default: ;
      endcase
    end
  end

  logic            phase_q;
  logic [BL_W-1:0] bl_cnt_q;

  // Outside SET states the blink state idles at zero, which also covers entry to SET_M10.
  always_ff @(posedge CLOCK_50_B5B or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= 1'b0;
      bl_cnt_q <= '0;
    end else if (!is_set || inc_evt || dec_evt) begin
      phase_q  <= 1'b0;
      bl_cnt_q <= '0;
    end else if (bl_cnt_q == BL_MAX) begin
      phase_q  <= ~phase_q;
      bl_cnt_q <= '0;
    end else begin
      bl_cnt_q <= bl_cnt_q + 1'b1;
    end
  end

  logic unused_cur;
  assign unused_cur = ^{cur_s1[4], cur_s10[4], cur_m1[4], cur_m10[4]};

  always_comb begin
    hold       = 1'b0;
    load       = 1'b0;
    editing    = 1'b0;
    blink_mask = '0;
    ld_s1      = '0;
    ld_s10     = '0;
    ld_m1      = '0;
    ld_m10     = '0;
    unique case (state_q)
      ST_SET_M10: begin hold = 1'b1; editing = 1'b1; blink_mask = {phase_q, 3'b000}; end
      ST_SET_M1:  begin hold = 1'b1; editing = 1'b1; blink_mask = {1'b0, phase_q, 2'b00}; end
      ST_SET_S10: begin hold = 1'b1; editing = 1'b1; blink_mask = {2'b00, phase_q, 1'b0}; end
      ST_SET_S1:  begin hold = 1'b1; editing = 1'b1; blink_mask = {3'b000, phase_q}; end
      ST_COMMIT: begin
        hold   = 1'b1;
        load   = 1'b1;
        ld_m10 = {1'b0, e_m10_q};
        ld_m1  = {1'b0, e_m1_q};
        ld_s10 = {1'b0, e_s10_q};
        ld_s1  = {1'b0, e_s1_q};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl with short debounce/blink/timeout periods.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_mode_n, key_inc_n, key_dec_n;
  logic [4:0] cur_s1, cur_s10, cur_m1, cur_m10;
  logic       hold, load, editing;
  logic [4:0] ld_s1, ld_s10, ld_m1, ld_m10;
  logic [3:0] blink_mask;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned load_cnt = 0;
  int unsigned inc_evt_cnt = 0;
  logic [4:0]  cap_m10, cap_m1, cap_s10, cap_s1;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_CYCLES(8),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .CLOCK_50_B5B(clk),
    .rst_n(rst_n),
    .key_mode_n(key_mode_n),
    .key_inc_n(key_inc_n),
    .key_dec_n(key_dec_n),
    .cur_s1(cur_s1),
    .cur_s10(cur_s10),
    .cur_m1(cur_m1),
    .cur_m10(cur_m10),
    .hold(hold),
    .load(load),
    .ld_s1(ld_s1),
    .ld_s10(ld_s10),
    .ld_m1(ld_m1),
    .ld_m10(ld_m10),
    .blink_mask(blink_mask),
    .editing(editing)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load) begin
      load_cnt <= load_cnt + 1;
      cap_m10  <= ld_m10;
      cap_m1   <= ld_m1;
      cap_s10  <= ld_s10;
      cap_s1   <= ld_s1;
    end
    if (dut.evt_q[1]) inc_evt_cnt <= inc_evt_cnt + 1;
  end

  // k: bit0 mode, bit1 inc, bit2 dec. Event is consumed on the 8th edge after the press.
  task automatic press(input logic [2:0] k);
    @(negedge clk);
    key_mode_n = ~k[0];
    key_inc_n  = ~k[1];
    key_dec_n  = ~k[2];
    repeat (8) @(posedge clk);
    @(negedge clk);
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    key_dec_n  = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cur(input logic [4:0] m10, input logic [4:0] m1,
                         input logic [4:0] s10, input logic [4:0] s1);
    cur_m10 = m10; cur_m1 = m1; cur_s10 = s10; cur_s1 = s1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({hold, load, editing, blink_mask} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000", {hold, load, editing, blink_mask});
    end
    n_chk++;
    if ({ld_m10, ld_m1, ld_s10, ld_s1} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_ld: got %h want 00000", {ld_m10, ld_m1, ld_s10, ld_s1});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({hold, editing} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_after_release: hold/editing got %b want 00", {hold, editing});
    end
  endtask

  task automatic test_debounce;
    int unsigned base, n;
    set_cur(5'd1, 5'd2, 5'd3, 5'd4);
    press(3'b001);
    base = inc_evt_cnt;
    for (int c = 0; c < 20; c++) begin
      key_inc_n = ((c / 2) % 2) != 0;
      @(negedge clk);
    end
    key_inc_n = 1'b0;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (dut.evt_q[1]) break;
    end
    n_chk++;
    if (n !== 7) begin
      n_fail++;
      $display("FAIL debounce_latency: got %0d cycles want 7", n);
    end
    @(negedge clk);
    key_inc_n = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++;
    if (inc_evt_cnt - base !== 1) begin
      n_fail++;
      $display("FAIL debounce_count: got %0d events want 1", inc_evt_cnt - base);
    end
    base = load_cnt;
    repeat (4) press(3'b001);
    n_chk++;
    if (load_cnt - base !== 1 || {cap_m10, cap_m1, cap_s10, cap_s1} !== {5'd2, 5'd2, 5'd3, 5'd4}) begin
      n_fail++;
      $display("FAIL debounce_digit: loads %0d ld %0d%0d:%0d%0d want 1 loads 22:34",
               load_cnt - base, cap_m10, cap_m1, cap_s10, cap_s1);
    end
  endtask

  task automatic test_full_session;
    int unsigned base;
    logic [2:0] seq [14];
    seq = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b100, 3'b001, 3'b001,
            3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001};
    set_cur(5'd1, 5'd2, 5'd3, 5'd4);
    base = load_cnt;
    for (int i = 0; i < 13; i++) begin
      press(seq[i]);
      n_chk++;
      if (hold !== 1'b1 || load_cnt != base) begin
        n_fail++;
        $display("FAIL session_hold_%0d: hold %b loads %0d want hold 1 loads 0",
                 i, hold, load_cnt - base);
      end
    end
    press(seq[13]);
    repeat (20) @(negedge clk);
    n_chk++;
    if (load_cnt - base !== 1) begin
      n_fail++;
      $display("FAIL session_load_count: got %0d want 1", load_cnt - base);
    end
    n_chk++;
    if ({cap_m10, cap_m1, cap_s10, cap_s1} !== {5'd2, 5'd0, 5'd3, 5'd0}) begin
      n_fail++;
      $display("FAIL session_ld: got %0d%0d:%0d%0d want 20:30", cap_m10, cap_m1, cap_s10, cap_s1);
    end
    n_chk++;
    if ({hold, editing} !== 2'b00) begin
      n_fail++;
      $display("FAIL session_end: hold/editing got %b want 00", {hold, editing});
    end
  endtask

  task automatic test_wrap;
    int unsigned base;
    set_cur(5'd0, 5'd0, 5'd5, 5'd7);
    base = load_cnt;
    press(3'b001); press(3'b001); press(3'b100);
    press(3'b001); press(3'b010);
    press(3'b001); press(3'b001);
    n_chk++;
    if (load_cnt - base !== 1 || {cap_m10, cap_m1, cap_s10, cap_s1} !== {5'd0, 5'd9, 5'd0, 5'd7}) begin
      n_fail++;
      $display("FAIL wrap_inc: loads %0d ld %0d%0d:%0d%0d want 1 loads 09:07",
               load_cnt - base, cap_m10, cap_m1, cap_s10, cap_s1);
    end
    set_cur(5'd3, 5'd8, 5'd0, 5'd9);
    press(3'b001); press(3'b001); press(3'b001); press(3'b100);
    press(3'b001); press(3'b001);
    n_chk++;
    if ({cap_m10, cap_m1, cap_s10, cap_s1} !== {5'd3, 5'd8, 5'd5, 5'd9}) begin
      n_fail++;
      $display("FAIL wrap_dec: ld %0d%0d:%0d%0d want 38:59", cap_m10, cap_m1, cap_s10, cap_s1);
    end
    // Captured values above range clamp to the maximum; bit 4 is dropped first.
    set_cur(5'd25, 5'd31, 5'd7, 5'd19);
    repeat (5) press(3'b001);
    n_chk++;
    if ({cap_m10, cap_m1, cap_s10, cap_s1} !== {5'd5, 5'd9, 5'd5, 5'd3}) begin
      n_fail++;
      $display("FAIL clamp: ld %0d%0d:%0d%0d want 59:53", cap_m10, cap_m1, cap_s10, cap_s1);
    end
  endtask

  task automatic test_blink;
    logic [3:0] exp;
    set_cur(5'd0, 5'd0, 5'd0, 5'd0);
    n_chk++;
    if (blink_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL blink_run: got %b want 0000", blink_mask);
    end
    press(3'b001); press(3'b001);
    @(negedge clk);
    key_inc_n = 1'b0;
    repeat (8) @(posedge clk);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 0) key_inc_n = 1'b1;
      exp = (k >= 8 && k < 16) ? 4'b0100 : 4'b0000;
      n_chk++;
      if (blink_mask !== exp) begin
        n_fail++;
        $display("FAIL blink_k%0d: got %b want %b", k, blink_mask, exp);
      end
    end
    repeat (3) press(3'b001);
    n_chk++;
    if (blink_mask !== 4'b0000 || cap_m1 !== 5'd1) begin
      n_fail++;
      $display("FAIL blink_exit: mask %b m1 %0d want 0000 1", blink_mask, cap_m1);
    end
  endtask

  task automatic test_priority;
    int unsigned base;
    set_cur(5'd1, 5'd4, 5'd2, 5'd6);
    base = load_cnt;
    press(3'b010);
    n_chk++;
    if ({hold, editing} !== 2'b00) begin
      n_fail++;
      $display("FAIL inc_in_run: hold/editing got %b want 00", {hold, editing});
    end
    press(3'b001);
    press(3'b011);
    press(3'b110);
    press(3'b001); press(3'b001);
    n_chk++;
    if (load_cnt != base) begin
      n_fail++;
      $display("FAIL priority_early_load: got %0d loads want 0", load_cnt - base);
    end
    press(3'b001);
    n_chk++;
    if (load_cnt - base !== 1 || {cap_m10, cap_m1, cap_s10, cap_s1} !== {5'd1, 5'd4, 5'd2, 5'd6}) begin
      n_fail++;
      $display("FAIL priority_ld: loads %0d ld %0d%0d:%0d%0d want 1 loads 14:26",
               load_cnt - base, cap_m10, cap_m1, cap_s10, cap_s1);
    end
  endtask

  task automatic test_reset_mid;
    int unsigned base;
    set_cur(5'd2, 5'd2, 5'd2, 5'd2);
    base = load_cnt;
    press(3'b001); press(3'b001); press(3'b001);
    n_chk++;
    if (editing !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_pre: editing got %b want 1", editing);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({hold, load, editing} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset_async: hold/load/editing got %b want 000", {hold, load, editing});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_chk++;
    if (load_cnt != base || {hold, editing} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset_after: loads %0d hold/editing %b want 0 00",
               load_cnt - base, {hold, editing});
    end
  endtask

  task automatic test_timeout;
    int unsigned base;
    set_cur(5'd0, 5'd1, 5'd0, 5'd1);
    base = load_cnt;
    press(3'b001);
    n_chk++;
    if (editing !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_enter: editing got %b want 1", editing);
    end
`ifdef SET_TIMEOUT_EN
    repeat (64) @(negedge clk);
    n_chk++;
    if ({hold, editing} !== 2'b00 || load_cnt != base) begin
      n_fail++;
      $display("FAIL timeout_expire: hold/editing %b loads %0d want 00 0",
               {hold, editing}, load_cnt - base);
    end
`else
    repeat (1000) @(negedge clk);
    n_chk++;
    if ({hold, editing} !== 2'b11) begin
      n_fail++;
      $display("FAIL timeout_persist: hold/editing got %b want 11", {hold, editing});
    end
    repeat (4) press(3'b001);
    n_chk++;
    if (load_cnt - base !== 1) begin
      n_fail++;
      $display("FAIL timeout_commit: got %0d loads want 1", load_cnt - base);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    key_dec_n  = 1'b1;
    set_cur(5'd0, 5'd0, 5'd0, 5'd0);
    test_reset;
    test_debounce;
    test_full_session;
    test_wrap;
    test_blink;
    test_priority;
    test_reset_mid;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time-set controller for the MM:SS seven-segment clock.
- Debounces the set-mode, increment and decrement keys and sequences an edit FSM across the four digits (M10, M1, S10, S1).
- Holds the running counters while editing, then issues a single-cycle parallel-load strobe with the edited digits.
- Drives per-digit blink masks to the display block.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a raw key must be stable before its debounced level changes (20 ms at 50 MHz).
- BLINK_CYCLES, 12500000, half-period of the blink phase toggle (2 Hz blink at 50 MHz).
- TIMEOUT_CYCLES, 500000000, idle cycles before a set session is abandoned (only with SET_TIMEOUT_EN).

Ports:
- CLOCK_50_B5B  in  1  system clock, 50 MHz, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- key_mode_n  in  1  raw set/advance key, active-low, asynchronous.
- key_inc_n  in  1  raw increment key, active-low, asynchronous.
- key_dec_n  in  1  raw decrement key, active-low, asynchronous.
- cur_s1, cur_s10, cur_m1, cur_m10  in  5 each  live counter values, binary.
- hold  out  1  freezes the second oscillator while high.
- load  out  1  one-cycle strobe; counters take the ld_* values.
- ld_s1, ld_s10, ld_m1, ld_m10  out  5 each  digit values to load, valid while load=1.
- blink_mask  out  4  bit0=S1, bit1=S10, bit2=M1, bit3=M10; 1 = blank this digit.
- editing  out  1  high in any SET state.

Behaviour:
- Reset: FSM=RUN; hold=0, load=0, ld_*=0, blink_mask=0, editing=0; debounced key levels=released; blink phase=0; all counters=0.
- Input conditioning:
  - Each raw key passes a 2-FF synchroniser, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronised samples; any mismatch restarts the count.
  - A press event is a one-cycle pulse on the debounced released->pressed edge.
  - Total latency from a raw edge to the event pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM states: RUN, SET_M10, SET_M1, SET_S10, SET_S1, COMMIT.
  - RUN + mode event -> SET_M10. In the same edge, the edit registers capture cur_* with the top bit dropped (4 bits), and hold goes to 1.
  - SET_M10 -> SET_M1 -> SET_S10 -> SET_S1 on each mode event.
  - SET_S1 + mode event -> COMMIT.
  - COMMIT lasts exactly 1 cycle. In COMMIT, load=1 and ld_* = edit registers (zero-extended to 5 bits). Next state is RUN; hold drops on the COMMIT->RUN edge.
- Edit arithmetic on the selected digit only:
  - S1 and M1 range 0-9. S10 and M10 range 0-5.
  - inc at the maximum wraps to 0; dec at 0 wraps to the maximum.
  - No carry or borrow into neighbouring digits.
  - Captured values above the range are clamped to the maximum on capture.
- Simultaneous events in the same cycle:
  - Mode has priority; inc and dec are ignored that cycle.
  - inc and dec together are ignored.
  - inc and dec are ignored in RUN and COMMIT.
- Blink:
  - The phase toggles every BLINK_CYCLES while editing.
  - The phase is forced to 0 and its counter is cleared on entry to SET_M10.
  - blink_mask has a single bit set (the selected digit) when phase=1, else 0. It is always 0 in RUN and COMMIT.
  - Any inc or dec event clears the phase to 0 and restarts its counter, so the edited digit is immediately visible.
- editing=1 in the SET_* states; hold=1 in the SET_* states and COMMIT.
- Reset asserted mid-session: return to RUN immediately, hold=0, no load pulse; the counters keep their last values.

Optional Feature:
- Macro: SET_TIMEOUT_EN.
- Defined:
  - An idle counter clears on any key event and on entry to SET_M10, and increments each cycle in SET_* states.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to RUN without a load pulse (edits discarded) and hold drops.
  - A key event in the same cycle as the timeout takes priority, and the counter clears.
- Undefined: no idle counter; a session persists until committed or reset.

Test Plan:
- Sim parameters: DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, TIMEOUT_CYCLES=64.
- Debounce: key_inc_n bounces 0/1 every 2 cycles for 20 cycles, then stays low -> exactly one inc event, 7 cycles after the final stable low; digit increments once.
- Full session: cur=12:34. Sequence mode, inc x1, mode, dec x2, mode, mode, inc x6, mode -> one-cycle load with ld_m10=2, ld_m1=0, ld_s10=3, ld_s1=0; hold high from the first mode event through COMMIT; no second load pulse.
- Wrap: in SET_S10 with value 5, inc -> 0; then dec -> 5. In SET_M1 with value 0, dec -> 9. Neighbouring digits unchanged.
- Blink: in SET_M1, blink_mask alternates 4'b0100 / 4'b0000 every 8 cycles. An inc event forces 0000 for the next 8 cycles. blink_mask=0 in RUN.
- Priority/reset: mode and inc events in the same cycle -> state advances, digit unchanged. rst_n low in SET_S10 -> hold=0, load never asserted, FSM in RUN.
- SET_TIMEOUT_EN: enter SET with no further keys -> after 64 cycles FSM=RUN, hold=0, load=0. Without the macro, state persists beyond 1000 cycles.
